// File: rtl/adf4159_pkg.sv
// adf4159_pkg: shared constants and FSM states for the ADF4159 serial receiver
package adf4159_pkg;
  localparam int FRAME_BITS = 32;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with a configurable reset value
module sync_2ff #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1, r_s2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end
  assign o_q = r_s2;
endmodule

// File: rtl/adf4159_spi_rx.sv
// adf4159_spi_rx: oversampled 3-wire serial receiver with frame check and register bank
module adf4159_spi_rx #(
  parameter int FRAME_BITS = adf4159_pkg::FRAME_BITS,
  parameter int NUM_REGS = adf4159_pkg::NUM_REGS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            spi_clk,
  input  logic                            spi_data,
  input  logic                            spi_le,
  output logic [FRAME_BITS-1:0]           rx_word,
  output logic [adf4159_pkg::ADDR_W-1:0]  rx_addr,
  output logic                            rx_valid,
  output logic                            frame_err,
  output logic                            busy,
  input  logic [adf4159_pkg::ADDR_W-1:0]  rd_addr,
  output logic [FRAME_BITS-1:0]           rd_data
);
  import adf4159_pkg::*;
  logic [2:0] w_sync, r_prev;
  logic w_clk_rise, w_le_fall, w_le_rise, w_check, w_full;
  state_t r_state, w_next;
  logic [FRAME_BITS-1:0] r_sr, r_word, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic r_valid, r_err;
  logic [FRAME_BITS-1:0] r_bank [NUM_REGS];
  // bit order: {le, data, clk}; all idle high
  sync_2ff #(.W(3), .RST_VAL(3'b111)) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d({spi_le, spi_data, spi_clk}),
    .o_q(w_sync)
  );
  assign w_clk_rise = w_sync[0] & ~r_prev[0];
  assign w_le_fall  = ~w_sync[2] & r_prev[2];
  assign w_le_rise  = w_sync[2] & ~r_prev[2];
  assign w_check    = r_state == S_CHECK;
  assign w_full     = r_cnt == CNT_W'(FRAME_BITS);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == S_IDLE)  ? (w_le_fall ? S_SHIFT : S_IDLE) :
             (r_state == S_SHIFT) ? (w_le_rise ? S_CHECK : S_SHIFT) : S_IDLE;
  end
  // data is stable across the whole low phase, so the delayed copy is safe to sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= '1;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_bank[i] <= '0;
    end else begin
      r_prev  <= w_sync;
      r_valid <= w_check & w_full;
      r_err   <= w_check & ~w_full;
      r_rd    <= r_bank[rd_addr];
      if (r_state == S_IDLE && w_le_fall) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else if (r_state == S_SHIFT && !w_le_rise && w_clk_rise) begin
        r_sr  <= {r_sr[FRAME_BITS-2:0], r_prev[1]};
        r_cnt <= (r_cnt == CNT_W'(FRAME_BITS + 1)) ? r_cnt : r_cnt + 1'b1;
      end
      if (w_check && w_full) begin
        r_word <= r_sr;
        r_addr <= r_sr[ADDR_W-1:0];
        r_bank[r_sr[ADDR_W-1:0]] <= r_sr;
      end
    end
  end
  assign rx_word   = r_word;
  assign rx_addr   = r_addr;
  assign rx_valid  = r_valid;
  assign frame_err = r_err;
  assign busy      = r_state != S_IDLE;
  assign rd_data   = r_rd;
endmodule

// File: tb/tb_adf4159_spi_rx.sv
// tb_adf4159_spi_rx: directed self-checking bench for adf4159_spi_rx
module tb_adf4159_spi_rx;
  logic clk = 0, rst = 1, spi_clk = 1, spi_data = 1, spi_le = 1;
  logic [2:0] rd_addr = 0;
  logic [31:0] rx_word, rd_data;
  logic [2:0] rx_addr;
  logic rx_valid, frame_err, busy;
  int total = 0, bad = 0, n_valid = 0, n_err = 0, n_both = 0;
  int v0, e0;
  adf4159_spi_rx dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_data(spi_data), .spi_le(spi_le),
    .rx_word(rx_word), .rx_addr(rx_addr), .rx_valid(rx_valid), .frame_err(frame_err),
    .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) n_valid++;
    if (frame_err) n_err++;
    if (rx_valid && frame_err) n_both++;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic shift_bits(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_clk = 0;
      spi_data = w[i];
      repeat (4) @(negedge clk);
      spi_clk = 1;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic send(input logic [63:0] w, input int n, input int hi);
    spi_le = 0;
    repeat (4) @(negedge clk);
    chk("busy_open", busy, 1);
    shift_bits(w, n);
    spi_le = 1;
    if (hi >= 4) begin
      repeat (3) @(negedge clk);
      chk("lat_early", {rx_valid, frame_err}, 0);
      @(negedge clk);
      chk("lat_pulse", {rx_valid, frame_err}, (n == 32) ? 2'b10 : 2'b01);
      chk("busy_idle", busy, 0);
      repeat (hi - 4) @(negedge clk);
    end else begin
      repeat (hi) @(negedge clk);
    end
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk($sformatf("bank%0d", a), rd_data, exp);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_word", rx_word, 0);
    chk("rst_addr", rx_addr, 0);
    chk("rst_pulses", {rx_valid, frame_err}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd", rd_data, 0);
    rst = 0;
    repeat (4) @(negedge clk);
    v0 = n_valid;
    send(64'h12345678, 32, 6);
    chk("t1_nvalid", n_valid - v0, 1);
    chk("t1_word", rx_word, 32'h12345678);
    chk("t1_addr", rx_addr, 0);
    rd(0, 32'h12345678);
    send(64'h8000000B, 32, 6);
    chk("t2_addr", rx_addr, 3);
    rd(3, 32'h8000000B);
    v0 = n_valid;
    e0 = n_err;
    send(64'h00000006, 31, 6);
    send(64'h1_00000005, 33, 6);
    chk("t3_nerr", n_err - e0, 2);
    chk("t3_nvalid", n_valid - v0, 0);
    chk("t3_word", rx_word, 32'h8000000B);
    rd(0, 32'h12345678);
    rd(3, 32'h8000000B);
    rd(5, 0);
    rd(6, 0);
    v0 = n_valid;
    e0 = n_err;
    spi_le = 0;
    repeat (4) @(negedge clk);
    shift_bits(64'hABCD, 16);
    rst = 1;
    spi_le = 1;
    spi_clk = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    chk("t4_nopulse", (n_valid - v0) + (n_err - e0), 0);
    chk("t4_busy", busy, 0);
    rd(3, 0);
    send(64'h00000007, 32, 6);
    chk("t4_addr", rx_addr, 7);
    rd(7, 32'h00000007);
    v0 = n_valid;
    send(64'h00000001, 32, 3);
    send(64'h00000002, 32, 3);
    repeat (8) @(negedge clk);
    chk("t5_nvalid", n_valid - v0, 2);
    rd(1, 32'h00000001);
    rd(2, 32'h00000002);
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < 5; i++) begin
      spi_clk = 0;
      repeat (4) @(negedge clk);
      spi_clk = 1;
      repeat (4) @(negedge clk);
      chk("t6_busy", busy, 0);
    end
    chk("t6_nopulse", (n_valid - v0) + (n_err - e0), 0);
    chk("t6_word", rx_word, 32'h00000002);
    e0 = n_err;
    spi_le = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("t7_busy", busy, 1);
    spi_le = 1;
    repeat (6) @(negedge clk);
    chk("t7_nerr", n_err - e0, 1);
    chk("excl", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
